// File: rtl/gpu_pkg.sv
// Shared types for the triangle front end: vertex/triangle payloads and the
// dispatcher state encoding.
package gpu_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOR_W  = 4;

  // Element [0] is x, [1] is y, [2] is z.
  typedef logic [2:0][31:0] vertex_t;

  typedef struct packed {
    vertex_t              p1;
    vertex_t              p2;
    vertex_t              p3;
    logic [COLOR_W-1:0]   color;
    logic                 last;
  } triangle_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} disp_state_t;

  // Bitwise x/y match of any vertex pair means zero area on screen.
  function automatic logic is_degenerate(input triangle_t t);
    return ((t.p1[0] == t.p2[0]) && (t.p1[1] == t.p2[1])) ||
           ((t.p2[0] == t.p3[0]) && (t.p2[1] == t.p3[1])) ||
           ((t.p1[0] == t.p3[0]) && (t.p1[1] == t.p3[1]));
  endfunction
endpackage

// File: rtl/tri_fifo.sv
// Triangle FIFO with wrapping pointers and occupancy count; head is always
// visible on rdata, pop only advances the read pointer.
module tri_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             push,
  input  logic             pop,
  input  triangle_t        wdata,
  output triangle_t        rdata,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  triangle_t     mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
endmodule

// File: rtl/triangle_dispatcher.sv
// Queues triangles and launches them one at a time into the rasterizer.
// Optional DEGENERATE_CULL_EN drops zero-area triangles at pop time.
module triangle_dispatcher
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_p1 [3],
  input  logic [31:0]        in_p2 [3],
  input  logic [31:0]        in_p3 [3],
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_last,
  output logic               start,
  output logic [31:0]        p1 [3],
  output logic [31:0]        p2 [3],
  output logic [31:0]        p3 [3],
  output logic [COLOR_W-1:0] color,
  input  logic               ru_done,
  output logic               busy,
  output logic               frame_done,
  output logic [CNT_W-1:0]   occupancy
);
  triangle_t          wr_tri;
  triangle_t          head;
  logic               push;
  logic               pop;
  logic               cull;
  disp_state_t        state;
  disp_state_t        state_nxt;
  vertex_t            v1, v2, v3;
  logic [COLOR_W-1:0] color_q;
  logic               last_q;

  assign wr_tri = {in_p1[2], in_p1[1], in_p1[0],
                   in_p2[2], in_p2[1], in_p2[0],
                   in_p3[2], in_p3[1], in_p3[0],
                   in_color, in_last};

  assign in_ready = (occupancy != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (occupancy != '0);

`ifdef DEGENERATE_CULL_EN
  assign cull = is_degenerate(head);
`else
  assign cull = 1'b0;
`endif

  tri_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk    (clk),
    .areset (areset),
    .push   (push),
    .pop    (pop),
    .wdata  (wr_tri),
    .rdata  (head),
    .count  (occupancy)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ru_done is deliberately not looked at in LAUNCH: a level left over from
  // the previous triangle must not retire the new one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop && !cull) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = BUSY;
      BUSY:    if (ru_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = (state == LAUNCH);
    busy  = (state != IDLE) || (occupancy != '0);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      v1         <= '0;
      v2         <= '0;
      v3         <= '0;
      color_q    <= '0;
      last_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        if (cull) begin
          frame_done <= head.last;
        end else begin
          v1      <= head.p1;
          v2      <= head.p2;
          v3      <= head.p3;
          color_q <= head.color;
          last_q  <= head.last;
        end
      end
      if ((state == BUSY) && ru_done) frame_done <= last_q;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_out
    assign p1[i] = v1[i];
    assign p2[i] = v2[i];
    assign p3[i] = v3[i];
  end
  assign color = color_q;
endmodule

// File: doc/triangle_dispatcher.md
Name: triangle_dispatcher

Overview:
Upstream feeder for rasterizer_unit. Buffers screen-space triangles (raster-coordinate IEEE-754 single-precision vertices plus 4-bit colour) from the transform stage in a small FIFO. Issues one triangle at a time to the rasterizer with a single-cycle start pulse, holding vertex/colour outputs stable until the rasterizer's done. Marks end-of-frame so the display side can swap buffers.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNT_W, $clog2(DEPTH)+1, width of occupancy count.

Ports:
clk  in  1  system clock, rising edge
areset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream triangle valid
in_ready  out  1  dispatcher can accept (FIFO not full)
in_p1, in_p2, in_p3  in  3x32 each (unpacked [3])  vertex x, y, z floats
in_color  in  4  palette index
in_last  in  1  triangle is last of frame
start  out  1  one-cycle launch pulse to rasterizer
p1, p2, p3  out  3x32 each  vertices to rasterizer, stable from start through done
color  out  4  colour to rasterizer
ru_done  in  1  rasterizer finished current triangle
busy  out  1  triangle in flight or FIFO non-empty
frame_done  out  1  one-cycle pulse after last triangle of frame completes
occupancy  out  CNT_W  FIFO entry count

Behaviour:
- Reset (async assert, sync release): FIFO empty, occupancy 0, state IDLE; start, busy, frame_done 0; p1..p3 all 32'h0; color 0; in_ready 1 after reset deasserts.
- Push: in_valid && in_ready at rising edge writes {p1,p2,p3,color,last}. in_ready = (occupancy != DEPTH), combinational from count only; no full-bypass. in_valid while !in_ready is ignored and holds no data.
- FSM states: IDLE, LAUNCH, BUSY.
  IDLE: if occupancy > 0, pop head into output registers and latch last_q; go to LAUNCH. Else stay.
  LAUNCH: start = 1 for exactly this cycle; go to BUSY. ru_done is ignored in this cycle.
  BUSY: wait for ru_done = 1. Then go to IDLE; frame_done = 1 on the next cycle if last_q, else 0.
- Rasterizer contract: done deasserts no later than the cycle after start. A level-held done from the previous triangle therefore cannot retire the new one.
- Latency: empty FIFO, push at edge N → start high in cycle N+2. Back-to-back triangles: one IDLE bubble between ru_done and the next pop. ru_done seen at edge M → next start at M+2.
- Push and pop in the same cycle: both take effect; occupancy unchanged. Pointers wrap modulo DEPTH.
- Output registers change only on pop; between pops they hold the last triangle.
- busy = (state != IDLE) || (occupancy != 0).
- areset mid-triangle: everything returns to reset values at once; the in-flight triangle and queued triangles are dropped. The rasterizer is reset by the same areset.

Optional Feature:
DEGENERATE_CULL_EN
- Defined: at pop, compare vertex x/y words bitwise. If p1==p2, p2==p3 or p1==p3 on both [0] and [1], the triangle is culled: no LAUNCH, return to IDLE next cycle, outputs keep the previous triangle. A culled triangle with last set still pulses frame_done one cycle after the pop.
- Not defined: every popped triangle is launched.

Decomposition:
- gpu_pkg holds:
  - vertex_t (logic [31:0] [3])
  - triangle_t struct {p1, p2, p3, color, last}
  - disp_state_t enum {IDLE, LAUNCH, BUSY}
  - SCREEN_W = 320, SCREEN_H = 240, COLOR_W = 4
- Sub-module tri_fifo (DEPTH, triangle_t payload, push/pop/count, wrap pointers) instantiated once.

Test Plan:
- Reset: pulse areset 1 cycle → in_ready 1, start 0, busy 0, occupancy 0, p1[0] 0.
- Single triangle: push p1={438c0000,428a0000,3f800000}, p2={42280000,428a0000,3f800000}, p3={42600000,43290000,3f800000}, color 4'h5, last 1 → start high exactly 2 cycles after push. p1..p3 and color match and stay stable. Drive ru_done 40 cycles later → frame_done pulses 1 cycle later, then busy 0.
- Fill: push 5 triangles with ru_done held 0 → 1st launched, next 4 fill FIFO, in_ready 0 at occupancy 4. The sixth in_valid is not accepted until ru_done.
- Stale done: hold ru_done 1 continuously → each triangle retires in BUSY's first cycle, never in LAUNCH. Start spacing is exactly 3 cycles.
- Reset mid-flight: 3 queued, one in BUSY, assert areset → occupancy 0, start 0, p1 zeroed, no frame_done.
- DEGENERATE_CULL_EN: push p2 == p1 (x, y), last 1 → no start pulse, frame_done pulses. Without macro → start pulses.
